// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl - load-use bubble insertion and multi-cycle mult/div front-end freeze.
// Outputs are decoded combinationally from the IDLE/WAIT state so starts and stalls take effect in the same cycle.
module hazard_stall_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [31:0]      decodeIR,
  input  logic [31:0]      executeIR,
  input  logic             flush,
  input  logic             md_ready,
  output logic             md_start_mult,
  output logic             md_start_div,
  output logic             stall_fd,
  output logic             stall_dx,
  output logic             bubble_dx,
  output logic             bubble_xm,
  output logic             md_result_sel,
  output logic             md_timeout,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_count
);

  localparam int TCNT_W = ($clog2(MD_TIMEOUT) > 5) ? $clog2(MD_TIMEOUT) : 5;
  localparam logic [TCNT_W-1:0] TCNT_LAST = TCNT_W'(MD_TIMEOUT - 1);

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
  logic [CNT_W-1:0]    stall_count_q, stall_count_d;

  logic [4:0] d_op, d_rd, d_rs, d_rt;
  logic [4:0] x_op, x_rd, x_alu;
  logic [4:0] src_a, src_b;
  logic       is_mult, is_div, is_md, load_use;
  logic       unused_bits;

  assign unused_bits = ^{decodeIR[11:0], executeIR[21:7], executeIR[1:0]};

  always_comb begin
    d_op    = decodeIR[31:27];
    d_rd    = decodeIR[26:22];
    d_rs    = decodeIR[21:17];
    d_rt    = decodeIR[16:12];
    x_op    = executeIR[31:27];
    x_rd    = executeIR[26:22];
    x_alu   = executeIR[6:2];
    // Branches, jr and sw read rd as a source in place of rt
    if (d_op == 5'b00010 || d_op == 5'b00110 || d_op == 5'b00100 || d_op == 5'b00111) begin
      src_a = d_rd;
      src_b = d_rs;
    end else begin
      src_a = d_rs;
      src_b = d_rt;
    end
    is_mult  = (x_op == 5'b00000) && (x_alu == 5'b00110);
    is_div   = (x_op == 5'b00000) && (x_alu == 5'b00111);
    is_md    = is_mult || is_div;
    load_use = (x_op == 5'b01000) && (x_rd != 5'd0) && ((x_rd == src_a) || (x_rd == src_b));
  end

  always_comb begin
    state_d       = state_q;
    tcnt_d        = tcnt_q;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    stall_fd      = 1'b0;
    stall_dx      = 1'b0;
    bubble_dx     = 1'b0;
    bubble_xm     = 1'b0;
    md_result_sel = 1'b0;
    md_timeout    = 1'b0;
    md_busy       = 1'b0;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (flush) begin
            state_d = IDLE;
          end else if (is_md) begin
            md_start_mult = is_mult;
            md_start_div  = is_div;
            stall_fd      = 1'b1;
            stall_dx      = 1'b1;
            bubble_xm     = 1'b1;
            state_d       = WAIT;
            tcnt_d        = '0;
          end else if (load_use) begin
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end
        WAIT: begin
          md_busy = 1'b1;
          if (md_ready) begin
            md_result_sel = 1'b1;
            state_d       = IDLE;
            tcnt_d        = '0;
          end else if (tcnt_q == TCNT_LAST) begin
            // Abandon the operation: the mult/div leaves execute as a nop
            md_timeout = 1'b1;
            bubble_xm  = 1'b1;
            state_d    = IDLE;
            tcnt_d     = '0;
          end else begin
            stall_fd  = 1'b1;
            stall_dx  = 1'b1;
            bubble_xm = 1'b1;
            tcnt_d    = tcnt_q + TCNT_W'(1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
    stall_count_d = stall_count_q;
    if (stall_fd && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      tcnt_q        <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tcnt_q        <= tcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb/tb_hazard_stall_ctrl.sv - table vectors, corner sequences and random run against a cycle-count model.
module tb_hazard_stall_ctrl;

  localparam int MD_TIMEOUT = 64;
  localparam int CNT_W      = 6;
  localparam int CNT_MAX    = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic [31:0]      decodeIR = '0;
  logic [31:0]      executeIR = '0;
  logic             flush = 1'b0;
  logic             md_ready = 1'b0;
  logic             md_start_mult, md_start_div, stall_fd, stall_dx, bubble_dx, bubble_xm;
  logic             md_result_sel, md_timeout, md_busy;
  logic [CNT_W-1:0] stall_count;

  hazard_stall_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .decodeIR(decodeIR), .executeIR(executeIR),
    .flush(flush), .md_ready(md_ready), .md_start_mult(md_start_mult),
    .md_start_div(md_start_div), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .md_result_sel(md_result_sel),
    .md_timeout(md_timeout), .md_busy(md_busy), .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic sfd, sdx, bdx, bxm, sm, sd, sel, tmo, busy;
  } outs_t;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic [31:0] e;
    logic        fl;
    logic [5:0]  exp;
  } vec_t;

  int pass_cnt = 0;
  int total_cnt = 0;

  // Model state: absolute cycle number, start cycle of the outstanding mult/div, stall total
  int m_cyc = 0;
  int m_start = 0;
  bit m_busy = 0;
  int m_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [31:0] enc(input int op, input int rd, input int rs, input int rt, input int alu);
    enc = {5'(op), 5'(rd), 5'(rs), 5'(rt), 5'd0, 5'(alu), 2'b00};
  endfunction

  function automatic outs_t dut_outs();
    dut_outs = '{stall_fd, stall_dx, bubble_dx, bubble_xm, md_start_mult, md_start_div,
                 md_result_sel, md_timeout, md_busy};
  endfunction

  function automatic bit ref_load_use(input logic [31:0] d, input logic [31:0] e);
    logic [4:0] srcs [2];
    int op;
    op = int'(d[31:27]);
    if (op == 2 || op == 6 || op == 4 || op == 7) srcs = '{d[26:22], d[21:17]};
    else srcs = '{d[21:17], d[16:12]};
    return (e[31:27] == 5'd8) && (e[26:22] != 5'd0) &&
           (e[26:22] == srcs[0] || e[26:22] == srcs[1]);
  endfunction

  function automatic outs_t model_eval(input logic [31:0] d, input logic [31:0] e,
                                       input logic fl, input logic rdy);
    outs_t o;
    bit mul, dv;
    o = '0;
    mul = (e[31:27] == 5'd0) && (e[6:2] == 5'd6);
    dv  = (e[31:27] == 5'd0) && (e[6:2] == 5'd7);
    if (m_busy) begin
      o.busy = 1;
      if (rdy) o.sel = 1;
      else if (m_cyc - m_start == MD_TIMEOUT) begin
        o.tmo = 1;
        o.bxm = 1;
      end else begin
        o.sfd = 1; o.sdx = 1; o.bxm = 1;
      end
    end else if (!fl) begin
      if (mul || dv) begin
        o.sm = mul; o.sd = dv;
        o.sfd = 1; o.sdx = 1; o.bxm = 1;
      end else if (ref_load_use(d, e)) begin
        o.sfd = 1; o.bdx = 1;
      end
    end
    return o;
  endfunction

  task automatic model_commit(input outs_t o);
    if (o.sfd && m_cnt < CNT_MAX) m_cnt++;
    if (o.sm || o.sd) begin
      m_busy = 1;
      m_start = m_cyc;
    end
    if (o.sel || o.tmo) m_busy = 0;
    m_cyc++;
  endtask

  // Called just after a rising edge; returns the outputs sampled at the falling edge
  task automatic run_cycle(input logic [31:0] d, input logic [31:0] e, input logic fl,
                           input logic rdy, output outs_t got, output int cnt_got);
    outs_t ex;
    decodeIR = d; executeIR = e; flush = fl; md_ready = rdy;
    @(negedge clock);
    ex = model_eval(d, e, fl, rdy);
    got = dut_outs();
    cnt_got = int'(stall_count);
    check($sformatf("cyc%0d outputs", m_cyc), 64'(got), 64'(ex));
    check($sformatf("cyc%0d stall_count", m_cyc), 64'(stall_count), 64'(m_cnt));
    @(posedge clock);
    model_commit(ex);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    decodeIR = enc(0, 4, 3, 2, 0);
    executeIR = enc(0, 5, 1, 2, 6);
    reset = 1'b1;
    #1;
    check("reset outputs", 64'(dut_outs()), 64'(0));
    check("reset stall_count", 64'(stall_count), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    decodeIR = '0; executeIR = '0; flush = 0; md_ready = 0;
    @(posedge clock);
    #1;
    m_busy = 0;
    m_cnt = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t vecs[$];
    outs_t g;
    int c, starts, busy_starts;
    logic [31:0] NOP, LW3, LW0, MUL, DIV;
    NOP = '0;
    LW3 = enc(8, 3, 1, 0, 0);
    LW0 = enc(8, 0, 1, 0, 0);
    MUL = enc(0, 5, 1, 2, 6);
    DIV = enc(0, 6, 1, 2, 7);

    vecs.push_back('{"lu_rs",     enc(0, 4, 3, 2, 0), LW3, 1'b0, 6'b101000});
    vecs.push_back('{"lu_rt",     enc(0, 4, 2, 3, 0), LW3, 1'b0, 6'b101000});
    vecs.push_back('{"lw_r0",     enc(0, 4, 0, 2, 0), LW0, 1'b0, 6'b000000});
    vecs.push_back('{"lu_flush",  enc(0, 4, 3, 2, 0), LW3, 1'b1, 6'b000000});
    vecs.push_back('{"rd_only_r", enc(0, 3, 1, 2, 0), LW3, 1'b0, 6'b000000});
    vecs.push_back('{"bne_rd",    enc(2, 3, 1, 0, 0), LW3, 1'b0, 6'b101000});
    vecs.push_back('{"blt_rs",    enc(6, 1, 3, 0, 0), LW3, 1'b0, 6'b101000});
    vecs.push_back('{"jr_rd",     enc(4, 3, 0, 0, 0), LW3, 1'b0, 6'b101000});
    vecs.push_back('{"sw_rs",     enc(7, 5, 3, 0, 0), LW3, 1'b0, 6'b101000});
    vecs.push_back('{"sw_rt",     enc(7, 5, 1, 3, 0), LW3, 1'b0, 6'b000000});
    vecs.push_back('{"mult",      enc(0, 4, 5, 2, 0), MUL, 1'b0, 6'b110110});
    vecs.push_back('{"div",       NOP,                DIV, 1'b0, 6'b110101});
    vecs.push_back('{"div_flush", NOP,                DIV, 1'b1, 6'b000000});
    vecs.push_back('{"alu_nomd",  enc(0, 4, 5, 2, 0), enc(0, 5, 1, 2, 5), 1'b0, 6'b000000});

    foreach (vecs[i]) begin
      do_reset();
      decodeIR = vecs[i].d; executeIR = vecs[i].e; flush = vecs[i].fl; md_ready = 0;
      @(negedge clock);
      check({vecs[i].name, " outs"},
            64'({stall_fd, stall_dx, bubble_dx, bubble_xm, md_start_mult, md_start_div}),
            64'(vecs[i].exp));
      @(posedge clock);
      #1;
      decodeIR = NOP; executeIR = NOP; flush = 0;
      @(negedge clock);
      check({vecs[i].name, " count"}, 64'(stall_count), 64'(vecs[i].exp[5]));
      @(posedge clock);
      #1;
    end

    // Multiply with result 8 cycles after start
    do_reset();
    run_cycle(NOP, MUL, 0, 0, g, c);
    check("mul start", 64'({g.sm, g.sd}), 64'(2'b10));
    for (int i = 1; i < 8; i++) run_cycle(NOP, MUL, 0, 0, g, c);
    run_cycle(NOP, MUL, 0, 1, g, c);
    check("mul ready sel", 64'({g.sel, g.sfd, g.sdx}), 64'(3'b100));
    run_cycle(NOP, NOP, 0, 0, g, c);
    check("mul stall_count", 64'(c), 64'(8));
    check("mul idle", 64'(g.busy), 64'(0));

    // Divide that never completes, stall_count saturates at 63
    do_reset();
    run_cycle(NOP, DIV, 0, 0, g, c);
    check("div start", 64'({g.sm, g.sd}), 64'(2'b01));
    for (int i = 1; i < MD_TIMEOUT; i++) run_cycle(NOP, DIV, 0, 0, g, c);
    run_cycle(NOP, DIV, 0, 0, g, c);
    check("timeout pulse", 64'({g.tmo, g.bxm, g.sfd}), 64'(3'b110));
    run_cycle(NOP, NOP, 0, 0, g, c);
    check("timeout idle", 64'({g.busy, g.tmo}), 64'(0));
    check("count saturated", 64'(c), 64'(CNT_MAX));

    // Back-to-back multiply then divide
    do_reset();
    starts = 0; busy_starts = 0;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] e;
      logic r;
      e = (i < 5) ? MUL : ((i < 9) ? DIV : NOP);
      r = (i == 4 || i == 8);
      run_cycle(NOP, e, 0, r, g, c);
      if (g.sm || g.sd) starts++;
      if (g.busy && (g.sm || g.sd)) busy_starts++;
    end
    check("b2b starts", 64'(starts), 64'(2));
    check("b2b start while busy", 64'(busy_starts), 64'(0));

    // Reset asserted in the middle of WAIT
    do_reset();
    run_cycle(NOP, MUL, 0, 0, g, c);
    for (int i = 0; i < 3; i++) run_cycle(NOP, MUL, 0, 0, g, c);
    #2;
    reset = 1'b1;
    #1;
    check("midwait reset outs", 64'(dut_outs()), 64'(0));
    check("midwait reset count", 64'(stall_count), 64'(0));
    @(negedge clock);
    reset = 1'b0;
    executeIR = NOP;
    @(posedge clock);
    #1;
    m_busy = 0; m_cnt = 0;
    run_cycle(NOP, NOP, 0, 1, g, c);
    check("ready ignored idle", 64'({g.sel, g.busy}), 64'(0));

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [31:0] d, e;
      int ops [7] = '{0, 8, 2, 6, 4, 7, 1};
      int alus [4] = '{0, 6, 7, 3};
      d = enc(ops[$urandom_range(0, 6)], $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), alus[$urandom_range(0, 3)]);
      e = enc(ops[$urandom_range(0, 6)], $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), alus[$urandom_range(0, 3)]);
      run_cycle(d, e, ($urandom_range(0, 9) == 0), ($urandom_range(0, 7) == 0), g, c);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
